// File: rtl/mac32_dot_seq.sv
// Dot-product sequencer: streams (B,C) pairs through an external FP32 MAC (A + B*C), accumulating in acc.
// Optional macro MAC32_DOT_SEQ_NAN_ABORT_EN: abort the run with err_o when the MAC returns a NaN.
module mac32_dot_seq #(
  parameter int unsigned PARM_XLEN = 32,
  parameter int unsigned MAC_LAT   = 1,
  parameter int unsigned LEN_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic [PARM_XLEN-1:0] init_i,
  input  logic                 elem_valid_i,
  output logic                 elem_ready_o,
  input  logic [PARM_XLEN-1:0] elem_b_i,
  input  logic [PARM_XLEN-1:0] elem_c_i,
  output logic [PARM_XLEN-1:0] mac_a_o,
  output logic [PARM_XLEN-1:0] mac_b_o,
  output logic [PARM_XLEN-1:0] mac_c_o,
  input  logic [PARM_XLEN-1:0] mac_result_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [PARM_XLEN-1:0] result_o,
  output logic [LEN_W-1:0]     remain_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MAC_LAT - 1);

  state_t               state, state_nxt;
  logic [PARM_XLEN-1:0] acc, acc_nxt;
  logic [PARM_XLEN-1:0] a_nxt, b_nxt, c_nxt;
  logic [LEN_W-1:0]     remain, remain_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic                 err_nxt;
  logic                 res_nan;

`ifdef MAC32_DOT_SEQ_NAN_ABORT_EN
  assign res_nan = (&mac_result_i[30:23]) && (|mac_result_i[22:0]);
`else
  assign res_nan = 1'b0;
`endif

  assign elem_ready_o = (state == FETCH);
  assign result_o     = acc;
  assign remain_o     = remain;

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    remain_nxt = remain;
    cnt_nxt    = cnt;
    a_nxt      = mac_a_o;
    b_nxt      = mac_b_o;
    c_nxt      = mac_c_o;
    err_nxt    = err_o;
    case (state)
      IDLE: begin
        if (start_i) begin
          acc_nxt    = init_i;
          remain_nxt = len_i;
          err_nxt    = 1'b0;
          state_nxt  = (len_i != '0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        if (elem_valid_i && elem_ready_o) begin
          a_nxt     = acc;
          b_nxt     = elem_b_i;
          c_nxt     = elem_c_i;
          cnt_nxt   = LAT_M1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          acc_nxt    = mac_result_i;
          remain_nxt = remain - LEN_W'(1);
          if (res_nan) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end else if (remain == LEN_W'(1)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = FETCH;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy_o also spans the cycle after DONE: a run shows len*(MAC_LAT+1) + stalls + 2 busy cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      remain  <= '0;
      cnt     <= '0;
      mac_a_o <= '0;
      mac_b_o <= '0;
      mac_c_o <= '0;
      err_o   <= 1'b0;
      done_o  <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      remain  <= remain_nxt;
      cnt     <= cnt_nxt;
      mac_a_o <= a_nxt;
      mac_b_o <= b_nxt;
      mac_c_o <= c_nxt;
      err_o   <= err_nxt;
      done_o  <= (state_nxt == DONE);
      busy_o  <= (state != IDLE) || (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_mac32_dot_seq.sv
// Bench for mac32_dot_seq: two instances (MAC_LAT 1 and 3) driven by a latency-accurate FP32 MAC stub.
module tb_mac32_dot_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st  [2];
  logic [7:0]  ln  [2];
  logic [31:0] ini [2];
  logic        vld [2];
  logic        rdy [2];
  logic [31:0] eb  [2];
  logic [31:0] ec  [2];
  logic [31:0] ma  [2];
  logic [31:0] mb  [2];
  logic [31:0] mc  [2];
  logic [31:0] mr  [2];
  logic        bsy [2];
  logic        dn  [2];
  logic [31:0] res [2];
  logic [7:0]  rem [2];
  logic        er  [2];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mac32_dot_seq #(.PARM_XLEN(32), .MAC_LAT(1), .LEN_W(8)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .start_i(st[0]), .len_i(ln[0]), .init_i(ini[0]),
    .elem_valid_i(vld[0]), .elem_ready_o(rdy[0]), .elem_b_i(eb[0]), .elem_c_i(ec[0]),
    .mac_a_o(ma[0]), .mac_b_o(mb[0]), .mac_c_o(mc[0]), .mac_result_i(mr[0]),
    .busy_o(bsy[0]), .done_o(dn[0]), .result_o(res[0]), .remain_o(rem[0]), .err_o(er[0]));

  mac32_dot_seq #(.PARM_XLEN(32), .MAC_LAT(3), .LEN_W(8)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .start_i(st[1]), .len_i(ln[1]), .init_i(ini[1]),
    .elem_valid_i(vld[1]), .elem_ready_o(rdy[1]), .elem_b_i(eb[1]), .elem_c_i(ec[1]),
    .mac_a_o(ma[1]), .mac_b_o(mb[1]), .mac_c_o(mc[1]), .mac_result_i(mr[1]),
    .busy_o(bsy[1]), .done_o(dn[1]), .result_o(res[1]), .remain_o(rem[1]), .err_o(er[1]));

  // FP32 helpers for normals and zeros; NaN inputs give the canonical quiet NaN.
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = 11'(x[30:23]) + 11'd896;
    d = {x[31], e, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_mac(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    if (is_nan(a) || is_nan(b) || is_nan(c)) return 32'h7FC00000;
    return r2f(f2r(a) + f2r(b) * f2r(c));
  endfunction

  // MAC stub: result for operands driven at edge t appears just before edge t+MAC_LAT, stale before.
  logic [31:0] p1;
  logic [31:0] p3 [3];
  always @(negedge clk) begin
    p1    <= fp_mac(ma[0], mb[0], mc[0]);
    p3[0] <= fp_mac(ma[1], mb[1], mc[1]);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mr[0] = p1;
  assign mr[1] = p3[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vb   [2][256];
  logic [31:0] vc   [2][256];
  int          vgap [2][256];

  bit          job      [2];
  int          job_len  [2];
  logic [31:0] acc_m    [2];
  int          k_m      [2];
  bit          hs_pend  [2];
  logic [31:0] hb       [2];
  logic [31:0] hc       [2];
  logic [31:0] held_a   [2];
  logic [31:0] held_b   [2];
  logic [31:0] held_c   [2];
  int          busy_cnt [2];
  int          rdy_cnt  [2];
  int          done_cnt [2];
  int          done_cyc [2];
  int          start_cyc[2];
  logic [31:0] exp_res  [2];
  int          exp_rem  [2];
  bit          exp_err  [2];
  int          exp_n    [2];
  logic [31:0] last_res [2];
  int          last_rem [2];
  bit          last_err [2];

  // Compare process: every falling edge, checks both instances against the element-level model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        for (int i = 0; i < 2; i++) begin
          if (rdy[i]) chk("busy_in_fetch", 32'(bsy[i]), 32'd1);
          if (hs_pend[i]) begin
            chk("mac_a", ma[i], acc_m[i]);
            chk("mac_b", mb[i], hb[i]);
            chk("mac_c", mc[i], hc[i]);
            held_a[i]  = acc_m[i];
            held_b[i]  = hb[i];
            held_c[i]  = hc[i];
            acc_m[i]   = fp_mac(acc_m[i], hb[i], hc[i]);
            k_m[i]     = k_m[i] + 1;
            hs_pend[i] = 1'b0;
          end else begin
            chk("mac_a_hold", ma[i], held_a[i]);
            chk("mac_b_hold", mb[i], held_b[i]);
            chk("mac_c_hold", mc[i], held_c[i]);
          end
          if (job[i]) begin
            if (bsy[i]) busy_cnt[i]++;
            if (rdy[i]) rdy_cnt[i]++;
            if (vld[i] && rdy[i]) begin
              chk("remain_at_accept", 32'(rem[i]), 32'(job_len[i] - k_m[i]));
              chk("result_at_accept", res[i], acc_m[i]);
              hb[i] = eb[i];
              hc[i] = ec[i];
              hs_pend[i] = 1'b1;
            end
            if (dn[i]) begin
              done_cnt[i]++;
              done_cyc[i] = cyc;
              chk("done_result", res[i], exp_res[i]);
              chk("done_remain", 32'(rem[i]), 32'(exp_rem[i]));
              chk("done_err", 32'(er[i]), 32'(exp_err[i]));
              chk("done_elems", 32'(k_m[i]), 32'(exp_n[i]));
            end
          end else begin
            chk("idle_result_hold", res[i], last_res[i]);
            chk("idle_remain", 32'(rem[i]), 32'(last_rem[i]));
            chk("idle_err", 32'(er[i]), 32'(last_err[i]));
            chk("idle_done", 32'(dn[i]), 32'd0);
            chk("idle_busy", 32'(bsy[i]), 32'd0);
          end
        end
      end
    end
  end

  task automatic clear_after_reset;
    for (int j = 0; j < 2; j++) begin
      job[j] = 1'b0; hs_pend[j] = 1'b0;
      held_a[j] = '0; held_b[j] = '0; held_c[j] = '0;
      last_res[j] = '0; last_rem[j] = 0; last_err[j] = 1'b0;
      st[j] = 1'b0; vld[j] = 1'b0;
    end
  endtask

  task automatic run_job(input int i, input logic [31:0] init_v, input int len_v,
                         input int abort_at, input bit poke);
    logic [31:0] a;
    int n, lat, exp_busy, t;
    bit e;
    lat = (i == 0) ? 1 : 3;
    a = init_v; n = 0; e = 1'b0; exp_busy = 2;
    for (int k = 0; k < len_v; k++) begin
      a = fp_mac(a, vb[i][k], vc[i][k]);
      n++;
      exp_busy += lat + 1 + vgap[i][k];
`ifdef MAC32_DOT_SEQ_NAN_ABORT_EN
      if (is_nan(a)) begin e = 1'b1; break; end
`endif
    end
    exp_res[i] = a; exp_n[i] = n; exp_rem[i] = len_v - n; exp_err[i] = e;
    acc_m[i] = init_v; k_m[i] = 0; hs_pend[i] = 1'b0; job_len[i] = len_v;
    busy_cnt[i] = 0; rdy_cnt[i] = 0; done_cnt[i] = 0; done_cyc[i] = -1;

    st[i] = 1'b1; ln[i] = 8'(len_v); ini[i] = init_v; job[i] = 1'b1;
    step;
    start_cyc[i] = cyc;
    st[i] = poke; ln[i] = 8'd7; ini[i] = 32'h12345678;

    for (int k = 0; k < len_v; k++) begin
      t = 0;
      while (!rdy[i] && done_cnt[i] == 0 && t < 300) begin step; t++; end
      if (done_cnt[i] != 0) break;
      if (!rdy[i]) begin chk("ready_timeout", 32'd0, 32'd1); break; end
      repeat (vgap[i][k]) step;
      vld[i] = 1'b1; eb[i] = vb[i][k]; ec[i] = vc[i][k];
      step;
      vld[i] = 1'b0; eb[i] = 32'h0BAD0BAD; ec[i] = 32'h0BAD0BAD;
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_result", res[i], 32'd0);
        chk("rst_mac_a", ma[i], 32'd0);
        chk("rst_mac_b", mb[i], 32'd0);
        chk("rst_mac_c", mc[i], 32'd0);
        chk("rst_remain", 32'(rem[i]), 32'd0);
        chk("rst_busy", 32'(bsy[i]), 32'd0);
        chk("rst_done", 32'(dn[i]), 32'd0);
        chk("rst_err", 32'(er[i]), 32'd0);
        chk("rst_ready", 32'(rdy[i]), 32'd0);
        clear_after_reset();
        repeat (3) step;
        rst_n = 1'b1;
        repeat (4) step;
        chk("no_done_after_abort", 32'(done_cnt[i]), 32'd0);
        return;
      end
    end

    t = 0;
    while (done_cnt[i] == 0 && t < 600) begin step; t++; end
    st[i] = 1'b0;
    chk("done_seen", 32'(done_cnt[i] != 0), 32'd1);
    repeat (3) step;
    chk("busy_cycles", 32'(busy_cnt[i]), 32'(exp_busy));
    chk("done_once", 32'(done_cnt[i]), 32'd1);
    chk("done_timing", 32'(done_cyc[i] - start_cyc[i]), 32'(exp_busy - 2));
    last_res[i] = exp_res[i]; last_rem[i] = exp_rem[i]; last_err[i] = exp_err[i];
    job[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < 2; j++) begin
      ln[j] = '0; ini[j] = '0; eb[j] = '0; ec[j] = '0; busy_cnt[j] = 0;
      for (int k = 0; k < 256; k++) begin vb[j][k] = '0; vc[j][k] = '0; vgap[j][k] = 0; end
    end
    clear_after_reset();
    rst_n = 1'b0;
    step; step;
    for (int j = 0; j < 2; j++) begin
      chk("reset_result", res[j], 32'd0);
      chk("reset_busy", 32'(bsy[j]), 32'd0);
      chk("reset_done", 32'(dn[j]), 32'd0);
      chk("reset_mac_a", ma[j], 32'd0);
      chk("reset_remain", 32'(rem[j]), 32'd0);
    end
    rst_n = 1'b1;

    // 3 x (1.0 * 2.0) from 0.0, started on the first edge after reset release
    for (int k = 0; k < 3; k++) begin vb[0][k] = 32'h3F800000; vc[0][k] = 32'h40000000; end
    run_job(0, 32'h00000000, 3, -1, 1'b1);
    chk("len3_result", res[0], 32'h40C00000);
    chk("len3_busy8", 32'(busy_cnt[0]), 32'd8);

    // len 0: immediate DONE, no element traffic
    run_job(0, 32'h3F800000, 0, -1, 1'b1);
    chk("len0_result", res[0], 32'h3F800000);
    chk("len0_no_ready", 32'(rdy_cnt[0]), 32'd0);
    chk("len0_done_latency", 32'(done_cyc[0] - start_cyc[0]), 32'd0);
    step;

    // MAC_LAT=3 with 5-cycle stall: 1 + 3*2 = 7, 7 + 0.5*8 = 11
    vb[1][0] = 32'h40400000; vc[1][0] = 32'h40000000; vgap[1][0] = 0;
    vb[1][1] = 32'h3F000000; vc[1][1] = 32'h41000000; vgap[1][1] = 5;
    run_job(1, 32'h3F800000, 2, -1, 1'b1);
    chk("stall_result", res[1], 32'h41300000);
    chk("stall_busy15", 32'(busy_cnt[1]), 32'd15);

    // single element, negative product: 5 + (-2)*3 = -1
    vb[1][0] = 32'hC0000000; vc[1][0] = 32'h40400000; vgap[1][0] = 0;
    run_job(1, 32'h40A00000, 1, -1, 1'b0);
    chk("neg_result", res[1], 32'hBF800000);

    // NaN in element 2 of 4
    for (int k = 0; k < 4; k++) begin vb[0][k] = 32'h3F800000; vc[0][k] = 32'h40000000; end
    vb[0][1] = 32'h7FC00000;
    run_job(0, 32'h00000000, 4, -1, 1'b0);
    chk("nan_result", res[0], 32'h7FC00000);
`ifdef MAC32_DOT_SEQ_NAN_ABORT_EN
    chk("nan_err", 32'(er[0]), 32'd1);
    chk("nan_remain", 32'(rem[0]), 32'd2);
    chk("nan_busy", 32'(busy_cnt[0]), 32'd6);
`else
    chk("nan_err", 32'(er[0]), 32'd0);
    chk("nan_remain", 32'(rem[0]), 32'd0);
    chk("nan_busy", 32'(busy_cnt[0]), 32'd10);
`endif

    // reset during WAIT of element 2 of 4, then a fresh run: 2 + 1*1 + 4*0.25 + (-0.5)*8 = 0
    for (int k = 0; k < 4; k++) begin vb[1][k] = 32'h3F800000; vc[1][k] = 32'h3F800000; vgap[1][k] = 0; end
    run_job(1, 32'h40000000, 4, 1, 1'b0);
    vb[1][0] = 32'h3F800000; vc[1][0] = 32'h3F800000; vgap[1][0] = 1;
    vb[1][1] = 32'h40800000; vc[1][1] = 32'h3E800000; vgap[1][1] = 0;
    vb[1][2] = 32'hBF000000; vc[1][2] = 32'h41000000; vgap[1][2] = 2;
    run_job(1, 32'h40000000, 3, -1, 1'b1);
    chk("after_abort_result", res[1], 32'h00000000);
    chk("after_abort_err", 32'(er[1]), 32'd0);

    // maximum length: 255 x (1.0 * 1.0)
    for (int k = 0; k < 255; k++) begin vb[0][k] = 32'h3F800000; vc[0][k] = 32'h3F800000; vgap[0][k] = 0; end
    run_job(0, 32'h00000000, 255, -1, 1'b0);
    chk("len255_result", res[0], 32'h437F0000);
    chk("len255_busy", 32'(busy_cnt[0]), 32'd512);

    step;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
